// File: rtl/fork_join_responder.sv
// Fork/join responder: one accepted start launches up to NUM_JOBS timed jobs in
// parallel. Each job finishes after its own cycle delay. A join event is raised
// according to the latched mode (all / any / none). The block returns to idle only
// after every launched job has completed.
module fork_join_responder #(
  parameter int NUM_JOBS = 3,
  parameter int CNT_W    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  output logic                      ready_o,
  input  logic [1:0]                mode_i,
  input  logic [NUM_JOBS-1:0]       job_en_i,
  input  logic [NUM_JOBS*CNT_W-1:0] job_delay_i,
  output logic [NUM_JOBS-1:0]       job_active_o,
  output logic [NUM_JOBS-1:0]       job_done_o,
  output logic                      join_done_o,
  output logic [2:0]                first_id_o,
  output logic [CNT_W-1:0]          elapsed_o
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {M_ALL = 2'd0, M_ANY = 2'd1, M_NONE = 2'd2, M_RSVD = 2'd3} mode_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e                state_q, state_d;
  mode_e                 mode_q;
  logic [NUM_JOBS-1:0]   active_q;
  logic [CNT_W-1:0]      remain_q [NUM_JOBS];
  logic                  joined_q;
  logic [CNT_W-1:0]      elapsed_q;
  logic [2:0]            first_id_q;

  logic                  fork_fire;
  logic [NUM_JOBS-1:0]   done_now;
  logic                  still_running;
  logic                  join_cond;
  logic                  join_fire;
  logic                  any_first_fire;
  logic [2:0]            lowest_id;

  assign fork_fire = start_i && (state_q == S_IDLE);

  // Job completion, join condition and lowest completing index for this cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    done_now  = '0;
    lowest_id = '0;
    for (int i = 0; i < NUM_JOBS; i++) begin
      done_now[i] = active_q[i] && (remain_q[i] == CNT_ONE);
    end
    for (int i = NUM_JOBS - 1; i >= 0; i--) begin
      if (done_now[i]) lowest_id = 3'(i);
    end
    still_running = |(active_q & ~done_now);
    case (mode_q)
      M_ANY:   join_cond = (|done_now) || (active_q == '0);
      M_NONE:  join_cond = 1'b1;
      default: join_cond = !still_running;  // join_all and the reserved encoding
    endcase
    join_fire      = (state_q == S_RUN) && !joined_q && join_cond;
    any_first_fire = join_fire && (mode_q == M_ANY) && (|done_now);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned with <= so all registers update from pre-edge values.
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: leave RUN once every job has finished and the join has been signalled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fork_fire) state_d = S_RUN;
      S_RUN:   if (!still_running && (joined_q || join_fire)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job timers, latched fork parameters, join bookkeeping and elapsed counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= M_ALL;
      active_q   <= '0;
      joined_q   <= 1'b0;
      elapsed_q  <= '0;
      first_id_q <= '0;
      // NOTE: the per-job timer array is only NUM_JOBS registers, so it is reset
      // along with everything else; a large memory would normally be left unreset.
      for (int i = 0; i < NUM_JOBS; i++) remain_q[i] <= '0;
    end else if (fork_fire) begin
      mode_q    <= mode_e'(mode_i);
      active_q  <= job_en_i;
      joined_q  <= 1'b0;
      elapsed_q <= CNT_ONE;
      for (int i = 0; i < NUM_JOBS; i++) begin
        // A zero delay behaves as a one-cycle delay.
        remain_q[i] <= (job_delay_i[i*CNT_W +: CNT_W] == '0) ? CNT_ONE
                                                              : job_delay_i[i*CNT_W +: CNT_W];
      end
    end else if (state_q == S_RUN) begin
      active_q <= active_q & ~done_now;
      for (int i = 0; i < NUM_JOBS; i++) begin
        if (active_q[i]) remain_q[i] <= remain_q[i] - CNT_ONE;
      end
      if (join_fire) joined_q <= 1'b1;
      if (any_first_fire) first_id_q <= lowest_id;
      // Count until the join cycle, then hold the result until the next fork.
      if (!joined_q && !join_fire && (elapsed_q != CNT_MAX)) elapsed_q <= elapsed_q + CNT_ONE;
    end
  end

  // Outputs: completion pulses are suppressed while reset is asserted.
  always_comb begin
    ready_o      = (state_q == S_IDLE);
    job_active_o = active_q;
    job_done_o   = rst_i ? '0 : done_now;
    join_done_o  = join_fire && !rst_i;
    elapsed_o    = elapsed_q;
    first_id_o   = any_first_fire ? lowest_id : first_id_q;
  end

endmodule
